// File: rtl/rv_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   arb_state_t    : arbiter FSM states (IDLE, FETCH, DATA)
//   DATA_W_DEFAULT : default address/data width
//   BE_NONE        : byte-enable pattern meaning "read"
//   is_write()     : true when a byte-enable pattern writes at least one byte
package rv_mem_pkg;

    localparam int DATA_W_DEFAULT = 32;

    localparam logic [3:0] BE_NONE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    function automatic logic is_write(input logic [3:0] be);
        return (be != BE_NONE);
    endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Wait-state timer for one memory transaction.
//   clk     : clock
//   rst_n   : asynchronous reset, active-high
//   clr     : restart the count (asserted at grant)
//   en      : a transaction cycle passed without mem_ready
//   expired : this en cycle is the MAX_WAIT-th one; the transaction must abort
module arb_wait_timer
    import rv_mem_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count unanswered transaction cycles since the last grant.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && !expired) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expire in the cycle whose increment would reach MAX_WAIT, so the abort
    // lands on the same edge the count would have become MAX_WAIT.
    assign expired = en && (cnt_r == LAST_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the IF-stage fetch port and the MEM-stage data port for a
// single shared memory. Data wins unless a fetch has waited FAIR_LIMIT data
// grants. Owns the memory bus, the wait/timeout FSM and the pipeline holds.
//   if_*   : fetch requester (req/addr in, gnt/rvalid/rdata out)
//   dm_*   : data requester (req/addr/we/wdata in, gnt/rvalid/rdata out)
//   mem_*  : memory bus (req/addr/we/wdata out, ready/rdata in)
//   stall_o, pc_en_o, if_id_en_o : pipeline hold controls
//   err_o  : pulses with the rvalid of a timed-out transaction
module mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int MAX_WAIT   = 15,
    parameter int FAIR_LIMIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [DATA_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic [DATA_W-1:0] dm_addr_i,
    input  logic [3:0]        dm_we_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [3:0]        mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              pc_en_o,
    output logic              if_id_en_o,
    output logic              err_o
);

    localparam int FAIR_W = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
    localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_LIMIT);

    arb_state_t        state_r;
    logic [FAIR_W-1:0] fair_cnt_r;
    logic              dm_gnt_q_r;
    logic              mem_req_r;
    logic [DATA_W-1:0] mem_addr_r;
    logic [3:0]        mem_we_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              if_rvalid_r;
    logic              dm_rvalid_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              err_r;

    logic              if_gnt_s;
    logic              dm_gnt_s;
    logic              busy_s;
    logic              expired_s;
    logic              stall_s;

    // Grant decision; only IDLE can grant, data first unless fetch is owed a turn.
    always_comb begin
        if_gnt_s = 1'b0;
        dm_gnt_s = 1'b0;
        if (state_r == IDLE) begin
            if (if_req_i && (!dm_req_i || (fair_cnt_r == FAIR_MAX))) begin
                if_gnt_s = 1'b1;
            end else if (dm_req_i) begin
                dm_gnt_s = 1'b1;
            end else begin
                if_gnt_s = 1'b0;
                dm_gnt_s = 1'b0;
            end
        end else begin
            if_gnt_s = 1'b0;
            dm_gnt_s = 1'b0;
        end
    end

    assign busy_s = (state_r == FETCH) || (state_r == DATA);

    arb_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (if_gnt_s || dm_gnt_s),
        .en      (busy_s && !mem_ready_i),
        .expired (expired_s)
    );

    // Arbiter FSM with its registered bus and response outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r     <= IDLE;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= '0;
            mem_we_r    <= BE_NONE;
            mem_wdata_r <= '0;
            if_rvalid_r <= 1'b0;
            dm_rvalid_r <= 1'b0;
            if_rdata_r  <= '0;
            dm_rdata_r  <= '0;
            err_r       <= 1'b0;
        end else begin
            // Response pulses last one cycle unless a completion sets them below.
            if_rvalid_r <= 1'b0;
            dm_rvalid_r <= 1'b0;
            if_rdata_r  <= '0;
            dm_rdata_r  <= '0;
            err_r       <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (if_gnt_s) begin
                        state_r     <= FETCH;
                        mem_req_r   <= 1'b1;
                        mem_addr_r  <= if_addr_i;
                        mem_we_r    <= BE_NONE;
                        mem_wdata_r <= '0;
                    end else if (dm_gnt_s) begin
                        state_r     <= DATA;
                        mem_req_r   <= 1'b1;
                        mem_addr_r  <= dm_addr_i;
                        mem_we_r    <= dm_we_i;
                        mem_wdata_r <= dm_wdata_i;
                    end else begin
                        mem_req_r <= 1'b0;
                    end
                end
                FETCH, DATA: begin
                    // mem_ready_i beats a simultaneous timeout.
                    if (mem_ready_i || expired_s) begin
                        state_r     <= IDLE;
                        mem_req_r   <= 1'b0;
                        if_rvalid_r <= (state_r == FETCH);
                        dm_rvalid_r <= (state_r == DATA);
                        err_r       <= !mem_ready_i;
                        if_rdata_r  <= (state_r == FETCH && mem_ready_i) ? mem_rdata_i : '0;
                        dm_rdata_r  <= (state_r == DATA && mem_ready_i && !is_write(mem_we_r))
                                       ? mem_rdata_i : '0;
                    end else begin
                        mem_req_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Fairness count: data grants taken while a fetch waits, cleared by a fetch grant.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            fair_cnt_r <= '0;
        end else if (if_gnt_s) begin
            fair_cnt_r <= '0;
        end else if (dm_gnt_s && if_req_i && (fair_cnt_r != FAIR_MAX)) begin
            fair_cnt_r <= fair_cnt_r + FAIR_W'(1);
        end else begin
            fair_cnt_r <= fair_cnt_r;
        end
    end

    // Remember a data grant so the hold covers the cycle right after it.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            dm_gnt_q_r <= 1'b0;
        end else begin
            dm_gnt_q_r <= dm_gnt_s;
        end
    end

    assign stall_s = (dm_req_i && !dm_gnt_s) || (state_r == DATA) ||
                     (!dm_rvalid_r && dm_gnt_q_r);

    assign if_gnt_o    = if_gnt_s;
    assign dm_gnt_o    = dm_gnt_s;
    assign if_rvalid_o = if_rvalid_r;
    assign if_rdata_o  = if_rdata_r;
    assign dm_rvalid_o = dm_rvalid_r;
    assign dm_rdata_o  = dm_rdata_r;
    assign mem_req_o   = mem_req_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_we_o    = mem_we_r;
    assign mem_wdata_o = mem_wdata_r;
    assign err_o       = err_r;
    assign stall_o     = stall_s;
    assign pc_en_o     = if_rvalid_r && !stall_s;
    assign if_id_en_o  = if_rvalid_r && !stall_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default parameters).
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i;
    logic [31:0] dm_addr_i;
    logic [3:0]  dm_we_i;
    logic [31:0] dm_wdata_i;
    logic        dm_gnt_o;
    logic        dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic        pc_en_o;
    logic        if_id_en_o;
    logic        err_o;

    int n_cmp;
    int n_err;

    mem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .dm_req_i    (dm_req_i),
        .dm_addr_i   (dm_addr_i),
        .dm_we_i     (dm_we_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_gnt_o    (dm_gnt_o),
        .dm_rvalid_o (dm_rvalid_o),
        .dm_rdata_o  (dm_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .pc_en_o     (pc_en_o),
        .if_id_en_o  (if_id_en_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Hard time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] gnt_order [6];
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        if_req_i = 1'b0; if_addr_i = 32'h0;
        dm_req_i = 1'b0; dm_addr_i = 32'h0; dm_we_i = 4'b0000; dm_wdata_i = 32'h0;
        mem_ready_i = 1'b0; mem_rdata_i = 32'h0;

        // Reset state
        tick();
        check_eq("rst_mem_req", 32'(mem_req_o), 32'd0);
        check_eq("rst_mem_addr", mem_addr_o, 32'h0);
        check_eq("rst_rvalid", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd0);
        check_eq("rst_stall_err", {30'd0, stall_o, err_o}, 32'd0);
        check_eq("rst_pc_en", {30'd0, pc_en_o, if_id_en_o}, 32'd0);
        tick();
        rst_n = 1'b0;
        tick();

        // Fetch only, zero-wait
        if_req_i = 1'b1; if_addr_i = 32'h10; #1;
        check_eq("f_gnt", {30'd0, if_gnt_o, dm_gnt_o}, 32'd2);
        tick();
        if_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h00500093; #1;
        check_eq("f_mem_req", 32'(mem_req_o), 32'd1);
        check_eq("f_mem_addr", mem_addr_o, 32'h10);
        check_eq("f_mem_we", 32'(mem_we_o), 32'd0);
        tick();
        mem_ready_i = 1'b0; #1;
        check_eq("f_rvalid", 32'(if_rvalid_o), 32'd1);
        check_eq("f_rdata", if_rdata_o, 32'h00500093);
        check_eq("f_pc_en", {30'd0, pc_en_o, if_id_en_o}, 32'd3);
        check_eq("f_err", 32'(err_o), 32'd0);
        tick();
        check_eq("f_after", {30'd0, if_rvalid_o, mem_req_o}, 32'd0);

        // Simultaneous fetch and data read
        if_req_i = 1'b1; if_addr_i = 32'h40;
        dm_req_i = 1'b1; dm_addr_i = 32'h200; dm_we_i = 4'b0000; #1;
        check_eq("s_gnt", {30'd0, if_gnt_o, dm_gnt_o}, 32'd1);
        tick();
        dm_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'hCAFE0001; #1;
        check_eq("s_stall_busy", 32'(stall_o), 32'd1);
        check_eq("s_mem_addr", mem_addr_o, 32'h200);
        check_eq("s_no_if_gnt", 32'(if_gnt_o), 32'd0);
        tick();
        mem_ready_i = 1'b0; #1;
        check_eq("s_dm_rvalid", 32'(dm_rvalid_o), 32'd1);
        check_eq("s_dm_rdata", dm_rdata_o, 32'hCAFE0001);
        check_eq("s_stall_rv", 32'(stall_o), 32'd0);
        check_eq("s_if_gnt_rv", 32'(if_gnt_o), 32'd1);
        tick();
        if_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h11111111; #1;
        check_eq("s_f_addr", mem_addr_o, 32'h40);
        check_eq("s_dm_rv_gone", 32'(dm_rvalid_o), 32'd0);
        tick();
        mem_ready_i = 1'b0; #1;
        check_eq("s_if_rdata", if_rdata_o, 32'h11111111);
        check_eq("s_if_pc_en", {30'd0, if_rvalid_o, pc_en_o}, 32'd3);
        tick();

        // Data write with one wait state
        dm_req_i = 1'b1; dm_addr_i = 32'h300; dm_we_i = 4'b0011; dm_wdata_i = 32'hDEADBEEF; #1;
        check_eq("w_gnt", 32'(dm_gnt_o), 32'd1);
        tick();
        dm_req_i = 1'b0; dm_we_i = 4'b0000; #1;
        check_eq("w_mem_we", 32'(mem_we_o), 32'h3);
        check_eq("w_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
        check_eq("w_mem_req", 32'(mem_req_o), 32'd1);
        tick();
        mem_ready_i = 1'b1; mem_rdata_i = 32'h12345678; #1;
        check_eq("w_still_busy", {30'd0, mem_req_o, stall_o}, 32'd3);
        tick();
        mem_ready_i = 1'b0; #1;
        check_eq("w_rvalid", {30'd0, dm_rvalid_o, err_o}, 32'd2);
        check_eq("w_rdata", dm_rdata_o, 32'h0);

        // Fairness: continuous requests on both ports, zero-wait memory
        gnt_order[0] = 2'b01; gnt_order[1] = 2'b01; gnt_order[2] = 2'b10;
        gnt_order[3] = 2'b01; gnt_order[4] = 2'b01; gnt_order[5] = 2'b10;
        if_req_i = 1'b1; if_addr_i = 32'h50;
        dm_req_i = 1'b1; dm_addr_i = 32'h600; dm_we_i = 4'b0000;
        mem_ready_i = 1'b1; mem_rdata_i = 32'h0; #1;
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("fair_%0d", k), {30'd0, if_gnt_o, dm_gnt_o}, 32'(gnt_order[k]));
            tick();
            if (k == 5) begin
                if_req_i = 1'b0;
                dm_req_i = 1'b0;
            end
            tick();
            #1;
        end
        mem_ready_i = 1'b0;

        // Timeout on a fetch: 15 cycles of mem_req, then rvalid + err with rdata 0
        if_req_i = 1'b1; if_addr_i = 32'h80; mem_rdata_i = 32'hFFFFFFFF; #1;
        check_eq("t_gnt", 32'(if_gnt_o), 32'd1);
        tick();
        if_req_i = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            #1;
            check_eq($sformatf("t_req_c%0d", c), 32'(mem_req_o), 32'd1);
            tick();
        end
        #1;
        check_eq("t_req_drop", 32'(mem_req_o), 32'd0);
        check_eq("t_rvalid_err", {30'd0, if_rvalid_o, err_o}, 32'd3);
        check_eq("t_rdata", if_rdata_o, 32'h0);
        tick();
        check_eq("t_pulse_end", {30'd0, if_rvalid_o, err_o}, 32'd0);

        // mem_ready in the 15th cycle beats the timeout
        if_req_i = 1'b1; if_addr_i = 32'h84; #1;
        check_eq("r_gnt", 32'(if_gnt_o), 32'd1);
        tick();
        if_req_i = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 15) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = 32'h0BADF00D;
            end
            tick();
        end
        mem_ready_i = 1'b0; #1;
        check_eq("r_rvalid_err", {30'd0, if_rvalid_o, err_o}, 32'd2);
        check_eq("r_rdata", if_rdata_o, 32'h0BADF00D);
        tick();

        // Reset during a data wait
        dm_req_i = 1'b1; dm_addr_i = 32'h400; dm_we_i = 4'b0000; #1;
        check_eq("x_gnt", 32'(dm_gnt_o), 32'd1);
        tick();
        dm_req_i = 1'b0;
        tick();
        tick();
        check_eq("x_busy", 32'(mem_req_o), 32'd1);
        #1;
        rst_n = 1'b1; #1;
        check_eq("x_req_async", 32'(mem_req_o), 32'd0);
        check_eq("x_stall", 32'(stall_o), 32'd0);
        tick();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq($sformatf("x_no_rv_%0d", c), {29'd0, dm_rvalid_o, if_rvalid_o, err_o}, 32'd0);
            tick();
        end
        if_req_i = 1'b1; if_addr_i = 32'h90; #1;
        check_eq("x_f_gnt", {30'd0, if_gnt_o, dm_gnt_o}, 32'd2);
        tick();
        if_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h00000013; #1;
        check_eq("x_f_addr", mem_addr_o, 32'h90);
        tick();
        mem_ready_i = 1'b0; #1;
        check_eq("x_f_rvalid", {30'd0, if_rvalid_o, err_o}, 32'd2);
        check_eq("x_f_rdata", if_rdata_o, 32'h00000013);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
